// File: rtl/syn_fifo_reader.sv
// Read-side controller: drains a syn_fifo and presents its words as a valid/ready stream.
// Optional stall-cycle counter output enabled by defining SYN_FIFO_READER_STALL_CNT_EN.
module syn_fifo_reader #(
    parameter int unsigned DATA_WIDTH = 18,
    parameter int unsigned LEN_WIDTH  = 16,
    parameter int unsigned RD_LATENCY = 1
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  start_i,
    input  logic [LEN_WIDTH-1:0]  len_i,
    input  logic                  stop_i,
    output logic                  busy_o,
    output logic                  done_o,
    output logic [LEN_WIDTH-1:0]  xfer_cnt_o,
    input  logic                  fifo_empty_i,
    output logic                  fifo_rd_o,
    output logic                  fifo_oe_o,
    input  logic [DATA_WIDTH-1:0] fifo_data_i,
`ifdef SYN_FIFO_READER_STALL_CNT_EN
    output logic [15:0]           stall_cnt_o,
`endif
    output logic                  m_valid_o,
    input  logic                  m_ready_i,
    output logic [DATA_WIDTH-1:0] m_data_o
);

    typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;

    state_t                state_q, state_d;
    logic [LEN_WIDTH-1:0]  len_q, issued_q, issued_nxt, xfer_q;
    logic [RD_LATENCY-1:0] tag_q;
    logic [DATA_WIDTH-1:0] buf0_q, buf1_q;
    logic [1:0]            occ_q;
    logic [2:0]            inflight;
    logic [2:0]            credit_used;
    logic                  push, pop, start_acc;

    assign push      = tag_q[RD_LATENCY-1];
    assign pop       = (occ_q != 2'd0) && m_ready_i;
    assign start_acc = (state_q == IDLE) && start_i;

    always_comb begin
        inflight = '0;
        for (int unsigned i = 0; i < RD_LATENCY; i++) begin
            inflight = inflight + 3'(tag_q[i]);
        end
    end

    // Credit is counted after this edge's pop, so a word leaving the buffer frees
    // a slot for a read in the same cycle and sustains one word per cycle.
    assign credit_used = inflight + {1'b0, occ_q} - {2'b00, pop};
    assign issued_nxt  = issued_q + LEN_WIDTH'(fifo_rd_o);

    always_comb begin
        state_d   = state_q;
        fifo_rd_o = 1'b0;
        fifo_oe_o = 1'b0;
        busy_o    = 1'b0;
        done_o    = 1'b0;
        case (state_q)
            IDLE: begin
                if (start_i) state_d = RUN;
            end
            RUN: begin
                fifo_oe_o = 1'b1;
                busy_o    = 1'b1;
                fifo_rd_o = !fifo_empty_i && !stop_i
                            && ((len_q == '0) || (issued_q < len_q))
                            && (credit_used < 3'd2);
                if (stop_i || ((len_q != '0) && (issued_nxt == len_q))) state_d = DRAIN;
            end
            DRAIN: begin
                fifo_oe_o = 1'b1;
                busy_o    = 1'b1;
                if ((inflight == '0) && (occ_q == 2'd0)) state_d = DONE;
            end
            DONE: begin
                done_o  = 1'b1;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) state_q <= IDLE;
        else       state_q <= state_d;
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            len_q    <= '0;
            issued_q <= '0;
            xfer_q   <= '0;
        end else if (start_acc) begin
            len_q    <= len_i;
            issued_q <= '0;
            xfer_q   <= '0;
        end else begin
            issued_q <= issued_nxt;
            if (pop) xfer_q <= xfer_q + 1'b1;
        end
    end

    generate
        if (RD_LATENCY > 1) begin : g_tag_shift
            always_ff @(posedge clk_i or posedge rst_i) begin
                if (rst_i) tag_q <= '0;
                else       tag_q <= {tag_q[RD_LATENCY-2:0], fifo_rd_o};
            end
        end else begin : g_tag_single
            always_ff @(posedge clk_i or posedge rst_i) begin
                if (rst_i) tag_q <= '0;
                else       tag_q <= fifo_rd_o;
            end
        end
    endgenerate

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            occ_q  <= 2'd0;
            buf0_q <= '0;
            buf1_q <= '0;
        end else begin
            case ({push, pop})
                2'b10: begin
                    if (occ_q == 2'd0) buf0_q <= fifo_data_i;
                    else               buf1_q <= fifo_data_i;
                    occ_q <= occ_q + 2'd1;
                end
                2'b01: begin
                    buf0_q <= buf1_q;
                    occ_q  <= occ_q - 2'd1;
                end
                2'b11: begin
                    if (occ_q == 2'd1) begin
                        buf0_q <= fifo_data_i;
                    end else begin
                        buf0_q <= buf1_q;
                        buf1_q <= fifo_data_i;
                    end
                end
                default: ;
            endcase
        end
    end

`ifdef SYN_FIFO_READER_STALL_CNT_EN
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i)                                                   stall_cnt_o <= '0;
        else if (start_acc)                                          stall_cnt_o <= '0;
        else if (m_valid_o && !m_ready_i && (stall_cnt_o != 16'hFFFF)) stall_cnt_o <= stall_cnt_o + 16'd1;
    end
`endif

    assign m_valid_o  = (occ_q != 2'd0);
    assign m_data_o   = buf0_q;
    assign xfer_cnt_o = xfer_q;

endmodule

// File: tb/tb_syn_fifo_reader.sv
// Directed bench for syn_fifo_reader: behavioural syn_fifo models feed a RD_LATENCY=1 and a RD_LATENCY=3 instance.
module tb_syn_fifo_reader;
    localparam int DW = 18;
    localparam int LW = 16;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic          rst, start, stop, ready;
    logic [LW-1:0] len;
    logic          busy, done, rd, oe, valid, fempty;
    logic [LW-1:0] xfer;
    logic [DW-1:0] data, fdata;

    logic          start3, stop3, ready3;
    logic [LW-1:0] len3;
    logic          busy3, done3, rd3, oe3, valid3, fempty3;
    logic [LW-1:0] xfer3;
    logic [DW-1:0] data3, fdata3;
`ifdef SYN_FIFO_READER_STALL_CNT_EN
    logic [15:0]   stall1, stall3;
`endif

    syn_fifo_reader #(.DATA_WIDTH(DW), .LEN_WIDTH(LW), .RD_LATENCY(1)) dut (
        .clk_i(clk), .rst_i(rst), .start_i(start), .len_i(len), .stop_i(stop),
        .busy_o(busy), .done_o(done), .xfer_cnt_o(xfer),
        .fifo_empty_i(fempty), .fifo_rd_o(rd), .fifo_oe_o(oe), .fifo_data_i(fdata),
`ifdef SYN_FIFO_READER_STALL_CNT_EN
        .stall_cnt_o(stall1),
`endif
        .m_valid_o(valid), .m_ready_i(ready), .m_data_o(data)
    );

    syn_fifo_reader #(.DATA_WIDTH(DW), .LEN_WIDTH(LW), .RD_LATENCY(3)) dut3 (
        .clk_i(clk), .rst_i(rst), .start_i(start3), .len_i(len3), .stop_i(stop3),
        .busy_o(busy3), .done_o(done3), .xfer_cnt_o(xfer3),
        .fifo_empty_i(fempty3), .fifo_rd_o(rd3), .fifo_oe_o(oe3), .fifo_data_i(fdata3),
`ifdef SYN_FIFO_READER_STALL_CNT_EN
        .stall_cnt_o(stall3),
`endif
        .m_valid_o(valid3), .m_ready_i(ready3), .m_data_o(data3)
    );

    // FIFO models: registered output, extra pipeline stages for the latency-3 instance
    logic [DW-1:0] mem  [0:63];
    logic [DW-1:0] mem3 [0:63];
    int unsigned   wp = 0, rp = 0, wp3 = 0, rp3 = 0;
    logic [DW-1:0] p0 = '0, p1 = '0, p2 = '0;

    assign fempty  = (wp == rp);
    assign fempty3 = (wp3 == rp3);
    assign fdata3  = p2;

    always @(posedge clk) begin
        if (rd) begin
            fdata <= mem[rp % 64];
            rp    <= rp + 1;
        end
        if (rd3) begin
            p0  <= mem3[rp3 % 64];
            rp3 <= rp3 + 1;
        end
        p1 <= p0;
        p2 <= p1;
    end

    int            cyc = 0, st_cyc = 0, st3_cyc = 0;
    logic [DW-1:0] rx_q [$];
    int            rx_cyc [$];
    logic [DW-1:0] rx3_q [$];
    int            rx3_cyc [$];
    int            done_n = 0, done3_n = 0, rd_n = 0, rd_empty_n = 0;
    int            out_n = 0, max_out = 0, stab_err = 0;
    logic          hold_q = 1'b0;
    logic [DW-1:0] hold_d = '0;

    always @(posedge clk) begin : mon
        int o;
        cyc <= cyc + 1;
        if (start)  st_cyc  <= cyc;
        if (start3) st3_cyc <= cyc;
        if (valid && ready) begin
            rx_q.push_back(data);
            rx_cyc.push_back(cyc);
        end
        if (valid3 && ready3) begin
            rx3_q.push_back(data3);
            rx3_cyc.push_back(cyc);
        end
        if (done)  done_n  <= done_n + 1;
        if (done3) done3_n <= done3_n + 1;
        if (rd) rd_n <= rd_n + 1;
        if (rd && fempty) rd_empty_n <= rd_empty_n + 1;
        o = out_n + (rd ? 1 : 0) - ((valid && ready) ? 1 : 0);
        out_n <= o;
        if (o > max_out) max_out <= o;
        if (hold_q && (!valid || (data !== hold_d))) stab_err <= stab_err + 1;
        hold_q <= valid && !ready;
        hold_d <= data;
    end

    int pass_cnt = 0, fail_cnt = 0, total_cnt = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total_cnt++;
        assert (obs === exp) pass_cnt++;
        else begin
            fail_cnt++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic push_word(input logic [DW-1:0] w);
        mem[wp % 64] = w;
        wp++;
    endtask

    task automatic push3_word(input logic [DW-1:0] w);
        mem3[wp3 % 64] = w;
        wp3++;
    endtask

    task automatic start_xfer(input logic [LW-1:0] l);
        start = 1'b1;
        len   = l;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic wait_done(input int maxc, input bit which, input string tag);
        bit seen = 1'b0;
        for (int k = 0; k < maxc && !seen; k++) begin
            @(negedge clk);
            if (which ? done3 : done) seen = 1'b1;
        end
        chk(tag, 32'(seen), 32'd1);
    endtask

    task automatic wait_xfer(input logic [LW-1:0] n, input int maxc, input string tag);
        bit seen = 1'b0;
        for (int k = 0; k < maxc && !seen; k++) begin
            @(negedge clk);
            if (xfer == n) seen = 1'b1;
        end
        chk(tag, 32'(seen), 32'd1);
    endtask

    int base, d0, r0, re0;

    initial begin
        rst = 1'b1; start = 1'b0; stop = 1'b0; ready = 1'b1; len = '0;
        start3 = 1'b0; stop3 = 1'b0; ready3 = 1'b1; len3 = '0;
        repeat (3) @(negedge clk);

        // reset state
        chk("rst_busy",  32'(busy),  32'd0);
        chk("rst_done",  32'(done),  32'd0);
        chk("rst_xfer",  32'(xfer),  32'd0);
        chk("rst_rd",    32'(rd),    32'd0);
        chk("rst_oe",    32'(oe),    32'd0);
        chk("rst_valid", 32'(valid), 32'd0);
        chk("rst_data",  32'(data),  32'd0);
        chk("rst_valid3", 32'(valid3), 32'd0);
        rst = 1'b0;
        @(negedge clk);

        // burst of 8, ready held high
        for (int i = 0; i < 8; i++) push_word(DW'(i));
        base = rx_q.size(); d0 = done_n; r0 = rd_n;
        start_xfer(16'd8);
        chk("t1_oe", 32'(oe), 32'd1);
        wait_done(40, 1'b0, "t1_done_seen");
        chk("t1_oe_done", 32'(oe), 32'd0);
        repeat (3) @(negedge clk);
        chk("t1_count", 32'(rx_q.size() - base), 32'd8);
        for (int i = 0; i < 8; i++) chk($sformatf("t1_data%0d", i), 32'(rx_q[base + i]), 32'(i));
        chk("t1_consecutive", 32'(rx_cyc[base + 7] - rx_cyc[base]), 32'd7);
        chk("t1_latency", 32'(rx_cyc[base] - st_cyc), 32'd3);
        chk("t1_done_once", 32'(done_n - d0), 32'd1);
        chk("t1_rd_cycles", 32'(rd_n - r0), 32'd8);
        chk("t1_xfer_hold", 32'(xfer), 32'd8);
        chk("t1_busy", 32'(busy), 32'd0);

        // burst of 4 with ready pattern 1,0,0,1
        for (int i = 0; i < 4; i++) push_word(DW'(16'h10 + i));
        base = rx_q.size(); d0 = done_n;
        start_xfer(16'd4);
        begin
            bit seen = 1'b0;
            for (int k = 0; k < 80 && !seen; k++) begin
                ready = ((k % 4) == 0) || ((k % 4) == 3);
                @(negedge clk);
                if (done) seen = 1'b1;
            end
            chk("t2_done_seen", 32'(seen), 32'd1);
        end
        ready = 1'b1;
        @(negedge clk);
        chk("t2_count", 32'(rx_q.size() - base), 32'd4);
        for (int i = 0; i < 4; i++) chk($sformatf("t2_data%0d", i), 32'(rx_q[base + i]), 32'(16'h10 + i));
        chk("t2_stable", 32'(stab_err), 32'd0);
        chk("t2_outstanding_le2", 32'(max_out <= 2), 32'd1);
        chk("t2_done_once", 32'(done_n - d0), 32'd1);
        chk("t2_xfer", 32'(xfer), 32'd4);

        // FIFO runs dry mid-burst
        push_word(18'h20); push_word(18'h21);
        base = rx_q.size(); d0 = done_n; r0 = rd_n; re0 = rd_empty_n;
        start_xfer(16'd5);
        repeat (20) @(negedge clk);
        chk("t3_wait_count", 32'(rx_q.size() - base), 32'd2);
        chk("t3_wait_busy",  32'(busy),  32'd1);
        chk("t3_wait_valid", 32'(valid), 32'd0);
        chk("t3_wait_rd",    32'(rd),    32'd0);
        for (int i = 2; i < 5; i++) push_word(DW'(18'h20 + i));
        wait_done(40, 1'b0, "t3_done_seen");
        @(negedge clk);
        chk("t3_count", 32'(rx_q.size() - base), 32'd5);
        for (int i = 0; i < 5; i++) chk($sformatf("t3_data%0d", i), 32'(rx_q[base + i]), 32'(18'h20 + i));
        chk("t3_rd_when_empty", 32'(rd_empty_n - re0), 32'd0);
        chk("t3_rd_cycles", 32'(rd_n - r0), 32'd5);
        chk("t3_done_once", 32'(done_n - d0), 32'd1);
        chk("t3_xfer", 32'(xfer), 32'd5);

        // continuous mode, stop with one read in flight
        for (int i = 0; i < 10; i++) push_word(DW'(18'h100 + i));
        base = rx_q.size(); d0 = done_n; r0 = rd_n;
        start_xfer(16'd0);
        wait_xfer(16'd10, 60, "t4_reach10");
        push_word(18'h10A);
        #1;
        chk("t4_rd_issue", 32'(rd), 32'd1);
        @(negedge clk);
        stop = 1'b1;
        push_word(18'h10B); push_word(18'h10C);
        #1;
        chk("t4_rd_stopped", 32'(rd), 32'd0);
        chk("t4_inflight_not_buffered", 32'(valid), 32'd0);
        wait_done(20, 1'b0, "t4_done_seen");
        stop = 1'b0;
        @(negedge clk);
        chk("t4_xfer", 32'(xfer), 32'd11);
        chk("t4_count", 32'(rx_q.size() - base), 32'd11);
        chk("t4_last", 32'(rx_q[base + 10]), 32'h10A);
        chk("t4_rd_cycles", 32'(rd_n - r0), 32'd11);
        chk("t4_done_once", 32'(done_n - d0), 32'd1);
        chk("t4_outstanding_le2", 32'(max_out <= 2), 32'd1);

        // reset mid-burst with two words buffered (FIFO still holds 10B,10C first)
        for (int i = 0; i < 4; i++) push_word(DW'(18'h30 + i));
        start_xfer(16'd6);
        wait_xfer(16'd2, 20, "t5_reach2");
        ready = 1'b0;
        repeat (5) @(negedge clk);
        chk("t5_pre_valid", 32'(valid), 32'd1);
        chk("t5_pre_head",  32'(data),  32'h30);
        d0 = done_n;
        rst = 1'b1;
        #1;
        chk("t5_rst_valid", 32'(valid), 32'd0);
        chk("t5_rst_busy",  32'(busy),  32'd0);
        chk("t5_rst_xfer",  32'(xfer),  32'd0);
        chk("t5_rst_data",  32'(data),  32'd0);
        @(negedge clk);
        rst = 1'b0;
        ready = 1'b1;
        repeat (2) @(negedge clk);
        chk("t5_no_done", 32'(done_n - d0), 32'd0);
        base = rx_q.size();
        start_xfer(16'd2);
        wait_done(30, 1'b0, "t5_done_seen");
        @(negedge clk);
        chk("t5_count", 32'(rx_q.size() - base), 32'd2);
        chk("t5_data0", 32'(rx_q[base]),     32'h32);
        chk("t5_data1", 32'(rx_q[base + 1]), 32'h33);
        chk("t5_xfer", 32'(xfer), 32'd2);
        chk("t5_done_once", 32'(done_n - d0), 32'd1);

        // RD_LATENCY=3 instance, burst of 6
        for (int i = 0; i < 6; i++) push3_word(DW'(18'h40 + i));
        base = rx3_q.size(); d0 = done3_n;
        start3 = 1'b1; len3 = 16'd6;
        @(negedge clk);
        start3 = 1'b0;
        wait_done(60, 1'b1, "t6_done_seen");
        @(negedge clk);
        chk("t6_count", 32'(rx3_q.size() - base), 32'd6);
        for (int i = 0; i < 6; i++) chk($sformatf("t6_data%0d", i), 32'(rx3_q[base + i]), 32'(18'h40 + i));
        chk("t6_latency", 32'(rx3_cyc[base] - st3_cyc), 32'd5);
        chk("t6_xfer", 32'(xfer3), 32'd6);
        chk("t6_done_once", 32'(done3_n - d0), 32'd1);
`ifdef SYN_FIFO_READER_STALL_CNT_EN
        chk("t6_stall_cnt", 32'(stall3), 32'd0);
`endif

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end
endmodule

// File: doc/syn_fifo_reader.md
Name: syn_fifo_reader

Overview:
- Read-side controller that drains a syn_fifo instance and re-presents its words as a valid/ready stream.
- Drives the FIFO's rd and oe pins and captures its registered output.
- Supports fixed-length bursts or continuous streaming.
- Holds at most 2 words (in-flight plus buffered), so downstream backpressure never drops or duplicates data.
- Sits between a syn_fifo read port and any stream consumer in the same read clock domain.

Parameters:
- DATA_WIDTH, 18, width of FIFO data and stream data.
- LEN_WIDTH, 16, width of burst length and transfer counter.
- RD_LATENCY, 1, clock edges from a fifo_rd_o pulse to valid fifo_data_i; legal range 1..4.

Ports:
- clk_i  input  1  read-domain clock; all logic on rising edge.
- rst_i  input  1  asynchronous reset, active-high.
- start_i  input  1  pulse; launches a transfer when in IDLE, ignored otherwise.
- len_i  input  LEN_WIDTH  burst length sampled on start_i; 0 = continuous.
- stop_i  input  1  level; ends a continuous transfer, or truncates a burst.
- busy_o  output  1  high in RUN or DRAIN.
- done_o  output  1  one-cycle pulse on DONE.
- xfer_cnt_o  output  LEN_WIDTH  words accepted downstream in the current transfer.
- fifo_empty_i  input  1  FIFO empty, active-high, accurate for the current cycle.
- fifo_rd_o  output  1  FIFO read strobe, one word per high cycle.
- fifo_oe_o  output  1  FIFO output enable.
- fifo_data_i  input  DATA_WIDTH  FIFO data output.
- m_valid_o  output  1  stream valid.
- m_ready_i  input  1  stream ready.
- m_data_o  output  DATA_WIDTH  stream data.

Behaviour:
- Interface: single clock clk_i; asynchronous active-high reset rst_i.
- Reset values: all outputs 0, state IDLE, buffer empty, in-flight tags cleared, counters 0.
- Reset mid-transfer discards buffered and in-flight words; there is no done_o.
- FSM states: IDLE, RUN, DRAIN, DONE.
- IDLE:
  - fifo_oe_o=0, fifo_rd_o=0.
  - start_i -> latch len_i into len_q; clear issue counter and xfer_cnt_o; go to RUN.
- RUN:
  - fifo_oe_o=1.
  - fifo_rd_o = !fifo_empty_i && !stop_i && (len_q==0 || issued<len_q) && (inflight+occupancy<2).
  - Go to DRAIN when stop_i=1, or when len_q!=0 and issued==len_q (including same-cycle final issue).
- DRAIN:
  - fifo_oe_o=1, fifo_rd_o=0.
  - Leave when inflight==0 && occupancy==0 -> DONE.
- DONE: done_o=1 for one cycle, fifo_oe_o=0 -> IDLE.
- start_i is ignored outside IDLE, including in the DONE cycle.
- In-flight tracking:
  - RD_LATENCY-deep shift register of valid tags.
  - A word issued at edge N is written into the buffer from fifo_data_i at edge N+RD_LATENCY.
- Buffer:
  - 2-entry FIFO, registered outputs.
  - m_data_o is the head entry; m_valid_o = occupancy!=0.
  - Credit rule: in-flight plus buffered never exceeds 2, so the buffer never overflows.
- Handshake:
  - A word transfers when m_valid_o && m_ready_i.
  - m_data_o is stable while m_valid_o=1 and m_ready_i=0.
  - Buffer push and pop in the same cycle are both honoured.
- Throughput: with RD_LATENCY=1 and m_ready_i held high, 1 word per cycle is sustained after 2-cycle first-word latency (rd at edge 0, data in buffer at edge 1, m_valid_o high from then).
- xfer_cnt_o:
  - Increments per accepted word and wraps modulo 2^LEN_WIDTH in continuous mode.
  - Holds its value after DONE until the next start_i.
- FIFO going empty mid-burst: RUN waits with fifo_rd_o=0; there is no timeout.
- stop_i: reads already issued still complete and are delivered.
- len_i max: (2^LEN_WIDTH)-1.

Optional Feature:
- Macro: SYN_FIFO_READER_STALL_CNT_EN.
- When defined:
  - Adds output stall_cnt_o, 16 bits.
  - Counts cycles with m_valid_o=1 && m_ready_i=0, saturating at 16'hFFFF.
  - Cleared on reset and on start_i accepted in IDLE.
- When undefined: the port and logic are absent; all other behaviour is identical.

Test Plan:
- FIFO preloaded with 8 words 0x00..0x07, len_i=8, m_ready_i=1 -> m_data_o 0x00..0x07 on consecutive cycles, done_o pulses once, xfer_cnt_o=8, fifo_rd_o high exactly 8 cycles.
- len_i=4, m_ready_i toggled 1,0,0,1,... -> no word lost or duplicated; m_data_o stable during stalls; never more than 2 rd pulses outstanding unaccepted.
- FIFO holds 2 words, len_i=5, 3 more words written 20 cycles later -> fifo_rd_o low while fifo_empty_i=1; all 5 words delivered in order; then done_o.
- len_i=0 continuous, stop_i asserted after 10 accepted words with 1 read in flight -> in-flight word still delivered, then DONE; xfer_cnt_o=11.
- rst_i asserted mid-burst with 2 words buffered -> m_valid_o=0, busy_o=0, xfer_cnt_o=0 immediately, no done_o; new start_i works normally.
- RD_LATENCY=3, len_i=6, m_ready_i=1 -> words arrive 3 edges after each rd, order preserved; with SYN_FIFO_READER_STALL_CNT_EN, stall_cnt_o=0.
